rx_word_align: RTL and testbench

Multi-channel receive word-alignment and capture block for the fabric side of I_SERDES deserialisers. For each of CHANNELS lanes it:
- waits for a stable DPA lock;
- trains word alignment by pulsing BITSLIP until a known training pattern is seen repeatedly;
- then registers aligned words to the fabric.

It sits between the I_SERDES Q/DATA_VALID/DPA_LOCK outputs and user logic. It replaces the fixed lock-wait counter with per-lane training, failure detection and retrain.

---
 rtl/rx_word_align.sv | 210 +++++++++++++++++++++
 tb/tb_rx_word_align.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rx_word_align.sv
// Purpose: per-lane DPA lock qualification, bitslip word-alignment training and aligned word capture for I_SERDES lanes.
// Latency: bitslip/aligned/align_error follow their cause by one cycle; an accepted word appears on data_out one cycle later.
// Backpressure: none; the deserialiser stream is free-running, and words seen outside ALIGNED are dropped.
module rx_word_align #(
   parameter int         WIDTH       = 4,
   parameter int         CHANNELS    = 2,
   parameter logic [9:0] PATTERN     = 10'h00A,
   parameter int         MATCH_COUNT = 4,
   parameter int         SLIP_WAIT   = 8,
   parameter int         LOCK_WAIT   = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         retrain,
   input  logic [CHANNELS-1:0]          dpa_lock,
   input  logic [CHANNELS-1:0]          data_valid,
   input  logic [CHANNELS*WIDTH-1:0]    data_in,
   output logic [CHANNELS-1:0]          bitslip,
   output logic [CHANNELS*WIDTH-1:0]    data_out,
   output logic [CHANNELS-1:0]          data_out_valid,
   output logic [CHANNELS-1:0]          aligned,
   output logic [CHANNELS-1:0]          align_error,
   output logic                         ready
);

   // Counter widths are sized so each counter can hold its terminal value.
   localparam int LOCK_W   = $clog2(LOCK_WAIT + 1);
   localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
   localparam int SLIP_W   = $clog2(WIDTH + 1);
   localparam int SETTLE_W = $clog2(SLIP_WAIT + 1);

   localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_WAIT - 1);
   localparam logic [LOCK_W-1:0]   LOCK_FULL   = LOCK_W'(LOCK_WAIT);
   localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
   localparam logic [MATCH_W-1:0]  MATCH_FULL  = MATCH_W'(MATCH_COUNT);
   localparam logic [SLIP_W-1:0]   SLIP_FULL   = SLIP_W'(WIDTH);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_WAIT - 1);
   localparam logic [WIDTH-1:0]    PAT         = PATTERN[WIDTH-1:0];

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_CHECK     = 3'd2,
      ST_SLIP      = 3'd3,
      ST_SETTLE    = 3'd4,
      ST_ALIGNED   = 3'd5,
      ST_FAIL      = 3'd6
   } lane_state_t;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      lane_state_t          state_q, state_d;
      logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
      logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
      logic [SLIP_W-1:0]    slip_cnt_q, slip_cnt_d;
      logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
      logic [WIDTH-1:0]     word;
      logic                 capture;
      logic [WIDTH-1:0]     dout_q;
      logic                 dout_vld_q;

      assign word = data_in[i*WIDTH +: WIDTH];

      // Lane state register and training counters.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q      <= ST_IDLE;
            lock_cnt_q   <= '0;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            settle_cnt_q <= '0;
         end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            settle_cnt_q <= settle_cnt_d;
         end
      end

      // Next-state and counter update; global controls override the per-state behaviour.
      always_comb begin
         state_d      = state_q;
         lock_cnt_d   = lock_cnt_q;
         match_cnt_d  = match_cnt_q;
         slip_cnt_d   = slip_cnt_q;
         settle_cnt_d = settle_cnt_q;
         capture      = 1'b0;

         if (!enable) begin
            state_d      = ST_IDLE;
            lock_cnt_d   = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            settle_cnt_d = '0;
         end else if (retrain && (state_q != ST_IDLE)) begin
            state_d      = ST_WAIT_LOCK;
            lock_cnt_d   = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            settle_cnt_d = '0;
         end else if (!dpa_lock[i] && ((state_q == ST_CHECK) || (state_q == ST_SLIP) ||
                                       (state_q == ST_SETTLE) || (state_q == ST_ALIGNED))) begin
            // Losing DPA lock invalidates any alignment already found.
            state_d      = ST_WAIT_LOCK;
            lock_cnt_d   = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            settle_cnt_d = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_WAIT_LOCK;
               end

               ST_WAIT_LOCK: begin
                  // Lock must be held continuously; any dropout restarts the count.
                  if (!dpa_lock[i]) begin
                     lock_cnt_d = '0;
                  end else if (lock_cnt_q == LOCK_LAST) begin
                     state_d     = ST_CHECK;
                     lock_cnt_d  = LOCK_FULL;
                     match_cnt_d = '0;
                     slip_cnt_d  = '0;
                  end else begin
                     lock_cnt_d = lock_cnt_q + 1'b1;
                  end
               end

               ST_CHECK: begin
                  if (data_valid[i]) begin
                     if (word == PAT) begin
                        if (match_cnt_q == MATCH_LAST) begin
                           state_d     = ST_ALIGNED;
                           match_cnt_d = MATCH_FULL;
                        end else begin
                           match_cnt_d = match_cnt_q + 1'b1;
                        end
                     end else begin
                        // Every bit position has been tried once slip_cnt reaches WIDTH.
                        match_cnt_d = '0;
                        if (slip_cnt_q == SLIP_FULL) begin
                           state_d = ST_FAIL;
                        end else begin
                           state_d = ST_SLIP;
                        end
                     end
                  end
               end

               ST_SLIP: begin
                  if (slip_cnt_q != SLIP_FULL) begin
                     slip_cnt_d = slip_cnt_q + 1'b1;
                  end
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end

               ST_SETTLE: begin
                  // The deserialiser output is unreliable right after a slip; skip it.
                  if (settle_cnt_q == SETTLE_LAST) begin
                     settle_cnt_d = '0;
                     state_d      = ST_CHECK;
                  end else begin
                     settle_cnt_d = settle_cnt_q + 1'b1;
                  end
               end

               ST_ALIGNED: begin
                  capture = data_valid[i];
               end

               ST_FAIL: begin
                  state_d = ST_FAIL;
               end

               default: begin
                  state_d      = ST_IDLE;
                  lock_cnt_d   = '0;
                  match_cnt_d  = '0;
                  slip_cnt_d   = '0;
                  settle_cnt_d = '0;
               end
            endcase
         end
      end

      // Capture register: holds the last aligned word, strobes valid for one cycle per word.
      always_ff @(posedge clk) begin
         if (reset) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
         end else begin
            dout_vld_q <= capture;
            if (capture) begin
               dout_q <= word;
            end
         end
      end

      assign bitslip[i]                   = (state_q == ST_SLIP);
      assign aligned[i]                   = (state_q == ST_ALIGNED);
      assign align_error[i]               = (state_q == ST_FAIL);
      assign data_out[i*WIDTH +: WIDTH]   = dout_q;
      assign data_out_valid[i]            = dout_vld_q;
   end

   assign ready = &aligned;

endmodule

// File: tb/tb_rx_word_align.sv
// Directed bench for rx_word_align: training, capture, failure, lock loss, priority and reset.
// Cycle n is the interval after the n-th counted rising edge; inputs change and outputs are sampled 1 time unit after the edge.
// Expected cycles are hand-derived from LOCK_WAIT=16, MATCH_COUNT=4, SLIP_WAIT=8, WIDTH=4.
module tb_rx_word_align;
   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        retrain;
   logic [1:0]  dpa_lock;
   logic [1:0]  data_valid;
   logic [3:0]  d0, d1;
   logic [7:0]  data_in;
   logic [1:0]  bitslip;
   logic [7:0]  data_out;
   logic [1:0]  data_out_valid;
   logic [1:0]  aligned;
   logic [1:0]  align_error;
   logic        ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [3:0] cap_words [3];

   assign data_in = {d1, d0};

   always #5 clk = ~clk;

   rx_word_align #(
      .WIDTH(4), .CHANNELS(2), .PATTERN(10'h00A),
      .MATCH_COUNT(4), .SLIP_WAIT(8), .LOCK_WAIT(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .retrain(retrain),
      .dpa_lock(dpa_lock), .data_valid(data_valid), .data_in(data_in),
      .bitslip(bitslip), .data_out(data_out), .data_out_valid(data_out_valid),
      .aligned(aligned), .align_error(align_error), .ready(ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      cap_words[0] = 4'h3;
      cap_words[1] = 4'h7;
      cap_words[2] = 4'hC;

      reset = 1'b1; enable = 1'b0; retrain = 1'b0;
      dpa_lock = 2'b00; data_valid = 2'b00; d0 = 4'h0; d1 = 4'h0;
      repeat (3) tick();
      chk("rst_bitslip", bitslip, 2'b00);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_dout_valid", data_out_valid, 2'b00);
      chk("rst_aligned", aligned, 2'b00);
      chk("rst_align_error", align_error, 2'b00);
      chk("rst_ready", ready, 1'b0);

      // Basic training: lane0 already aligned, lane1 one bit off.
      cyc = 0;
      reset = 1'b0; enable = 1'b1; dpa_lock = 2'b11; data_valid = 2'b11;
      d0 = 4'hA; d1 = 4'h5;
      while (cyc < 31) begin
         tick();
         chk("train_bitslip", bitslip, (cyc == 18) ? 2'b10 : 2'b00);
         if (cyc == 18) d1 = 4'hA;
         if (cyc == 16) chk("train_lockwait_not_aligned", aligned, 2'b00);
         if (cyc == 20) chk("lane0_before_align", aligned, 2'b00);
         if (cyc == 21) begin
            chk("lane0_aligned", aligned, 2'b01);
            chk("align_word_not_captured", data_out_valid, 2'b00);
         end
         if (cyc == 22) begin
            chk("first_capture_valid", data_out_valid, 2'b01);
            chk("first_capture_data", data_out, 8'h0A);
         end
         if (cyc == 30) begin
            chk("lane1_before_align", aligned, 2'b01);
            chk("ready_before_both", ready, 1'b0);
         end
         if (cyc == 31) begin
            chk("both_aligned", aligned, 2'b11);
            chk("ready_rise", ready, 1'b1);
         end
      end

      // Capture: no valid, then 3,7,C on lane0 only.
      data_valid = 2'b00;
      tick();
      chk("no_valid_strobe", data_out_valid, 2'b00);
      chk("no_valid_hold", data_out, 8'h0A);
      for (int n = 0; n < 3; n++) begin
         data_valid = 2'b01;
         d0 = cap_words[n];
         tick();
         chk("cap_valid", data_out_valid, 2'b01);
         chk("cap_data", data_out, {4'h0, cap_words[n]});
      end
      data_valid = 2'b00;
      d0 = 4'hA;
      tick();
      chk("cap_end_valid", data_out_valid, 2'b00);
      chk("cap_end_hold", data_out, 8'h0C);

      // Lock loss on lane1 for one cycle (cycle 36).
      dpa_lock = 2'b01; data_valid = 2'b11; d1 = 4'hA;
      tick();
      chk("lockloss_aligned", aligned, 2'b01);
      chk("lockloss_ready", ready, 1'b0);
      dpa_lock = 2'b11;
      while (cyc < 57) begin
         tick();
         chk("relock_bitslip", bitslip, 2'b00);
         if (cyc == 56) chk("relock_pending", aligned, 2'b01);
         if (cyc == 57) begin
            chk("relock_aligned", aligned, 2'b11);
            chk("relock_ready", ready, 1'b1);
         end
      end

      // Failure: retrain with lane1 stuck at zero.
      retrain = 1'b1; d1 = 4'h0;
      tick();
      retrain = 1'b0;
      chk("retrain_aligned_clear", aligned, 2'b00);
      chk("retrain_ready_clear", ready, 1'b0);
      while (cyc < 115) begin
         tick();
         chk("fail_bitslip", bitslip,
             (cyc == 75 || cyc == 85 || cyc == 95 || cyc == 105) ? 2'b10 : 2'b00);
         if (cyc == 78) chk("fail_lane0_aligned", aligned, 2'b01);
         if (cyc == 114) chk("fail_before_5th", align_error, 2'b00);
         if (cyc == 115) begin
            chk("fail_align_error", align_error, 2'b10);
            chk("fail_lane0_kept", aligned, 2'b01);
         end
      end
      repeat (2) tick();
      chk("fail_held", align_error, 2'b10);
      chk("fail_no_slip", bitslip, 2'b00);
      retrain = 1'b1;
      tick();
      retrain = 1'b0;
      chk("retrain_clears_error", align_error, 2'b00);
      chk("retrain_clears_aligned", aligned, 2'b00);
      while (cyc < 135) begin
         tick();
         chk("retrain_bitslip", bitslip, (cyc == 135) ? 2'b10 : 2'b00);
      end
      chk("pre_reset_dout", data_out[3:0], 4'hA);

      // Reset while lane1 is in SLIP.
      reset = 1'b1;
      tick();
      chk("rst_slip_bitslip", bitslip, 2'b00);
      chk("rst_slip_data_out", data_out, 8'h00);
      chk("rst_slip_valid", data_out_valid, 2'b00);
      chk("rst_slip_aligned", aligned, 2'b00);
      chk("rst_slip_error", align_error, 2'b00);
      chk("rst_slip_ready", ready, 1'b0);
      reset = 1'b0;
      while (cyc < 160) begin
         tick();
         if (cyc == 156) chk("post_rst_pending", aligned, 2'b00);
         if (cyc == 157) chk("post_rst_aligned", aligned, 2'b01);
      end

      // enable low together with retrain: IDLE wins, costing one extra cycle before WAIT_LOCK.
      enable = 1'b0; retrain = 1'b1;
      tick();
      enable = 1'b1; retrain = 1'b0;
      chk("prio_aligned", aligned, 2'b00);
      chk("prio_error", align_error, 2'b00);
      chk("prio_bitslip", bitslip, 2'b00);
      while (cyc < 182) begin
         tick();
         if (cyc == 179) chk("prio_lane1_slip", bitslip, 2'b10);
         if (cyc == 181) chk("prio_idle_delay", aligned, 2'b00);
         if (cyc == 182) chk("prio_realigned", aligned, 2'b01);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
